// File: rtl/opreg_arb_pkg.sv
// Shared types and default widths for the operand register arbiter.
// Round-robin helper: the requester that did not win last time gets priority.
package opreg_arb_pkg;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_ADDR_W      = 4;
   localparam int unsigned DEF_MATRIX_SIZE = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   typedef enum logic {
      OWN_HOST = 1'b0,
      OWN_ENG  = 1'b1
   } owner_e;

   // Host has priority in a conflict unless it won the previous one.
   function automatic logic host_wins(input owner_e last_owner);
      return (last_owner == OWN_ENG);
   endfunction

endpackage

// File: rtl/opreg_burst_ctr.sv
// Burst address pointer and remaining-word counter.
// Pointer wraps modulo 2^ADDR_WIDTH; done/last decode the remaining count.
module opreg_burst_ctr #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [ADDR_WIDTH:0]   i_len,
   input  logic                  i_step,
   output logic [ADDR_WIDTH-1:0] o_ptr,
   output logic                  o_done_c,
   output logic                  o_last_c
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [LEN_W-1:0]      r_remaining;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_remaining <= '0;
      end else if (i_load) begin
         r_ptr       <= i_base;
         r_remaining <= i_len;
      end else if (i_step) begin
         r_ptr       <= r_ptr + ADDR_WIDTH'(1);
         r_remaining <= r_remaining - LEN_W'(1);
      end
   end

   assign o_ptr    = r_ptr;
   assign o_done_c = (r_remaining == '0);
   assign o_last_c = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/operand_reg_arbiter.sv
// Shares the single-port operand register between single-beat host accesses
// and engine read bursts, resolving same-cycle conflicts round-robin.
module operand_reg_arbiter
   import opreg_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_W,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_W,
   parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  host_req_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_wdata_i,
   output logic                  host_gnt_o,
   output logic                  host_rvalid_o,
   output logic [DATA_WIDTH-1:0] host_rdata_o,
   input  logic                  eng_start_i,
   input  logic [ADDR_WIDTH-1:0] eng_base_i,
   input  logic [ADDR_WIDTH:0]   eng_len_i,
   output logic                  eng_busy_o,
   output logic                  eng_valid_o,
   input  logic                  eng_ready_i,
   output logic [DATA_WIDTH-1:0] eng_data_o,
   output logic                  eng_last_o,
   output logic [ADDR_WIDTH-1:0] addr_Mat_o,
   output logic [DATA_WIDTH-1:0] write_data_Mat_o,
   output logic                  write_en_Mat_o,
   input  logic [DATA_WIDTH-1:0] read_data_Mat_i
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;

   state_e                r_state;
   owner_e                r_last_owner;
   logic                  r_host_rvalid;
   logic [DATA_WIDTH-1:0] r_host_rdata;
   logic                  r_eng_busy;
   logic                  r_eng_valid;
   logic [DATA_WIDTH-1:0] r_eng_data;
   logic                  r_eng_last;

   logic                  w_eng_start;
   logic                  w_host_pri;
   logic [LEN_W-1:0]      w_len_clamped;
   logic                  w_host_gnt;
   logic                  w_eng_go;
   logic                  w_step;
   logic                  w_hs_last;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic                  w_done;
   logic                  w_last;

   // Zero-length starts are not requests at all, so they never cause a conflict.
   assign w_eng_start   = eng_start_i && (eng_len_i != '0);
   assign w_host_pri    = host_wins(r_last_owner);
   assign w_len_clamped = (eng_len_i > LEN_W'(MATRIX_SIZE)) ? LEN_W'(MATRIX_SIZE) : eng_len_i;
   assign w_hs_last     = r_eng_valid && eng_ready_i && r_eng_last;

   opreg_burst_ctr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_burst_ctr (
      .i_clk    (clk_i),
      .i_rst_n  (rst_ni),
      .i_load   (w_eng_go),
      .i_base   (eng_base_i),
      .i_len    (w_len_clamped),
      .i_step   (w_step),
      .o_ptr    (w_ptr),
      .o_done_c (w_done),
      .o_last_c (w_last)
   );

   // Grant decode and operand register port mux.
   always_comb begin
      w_host_gnt = 1'b0;
      w_eng_go   = 1'b0;
      w_step     = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      w_we       = 1'b0;
      if (r_state == ST_IDLE) begin
         if (host_req_i && (!w_eng_start || w_host_pri)) begin
            w_host_gnt = 1'b1;
            w_addr     = host_addr_i;
            w_wdata    = host_wdata_i;
            w_we       = host_we_i;
         end else if (w_eng_start) begin
            w_eng_go = 1'b1;
         end
      end else begin
         // Fetch the next word whenever the output slot is empty or draining.
         if (!w_done && (!r_eng_valid || eng_ready_i)) begin
            w_step = 1'b1;
            w_addr = w_ptr;
         end
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= ST_IDLE;
         r_last_owner  <= OWN_ENG;
         r_host_rvalid <= 1'b0;
         r_host_rdata  <= '0;
         r_eng_busy    <= 1'b0;
         r_eng_valid   <= 1'b0;
         r_eng_data    <= '0;
         r_eng_last    <= 1'b0;
      end else begin
         r_host_rvalid <= w_host_gnt && !host_we_i;
         if (w_host_gnt && !host_we_i) begin
            r_host_rdata <= read_data_Mat_i;
         end
         if (r_state == ST_IDLE) begin
            if (host_req_i && w_eng_start) begin
               r_last_owner <= w_host_pri ? OWN_HOST : OWN_ENG;
            end
            if (w_eng_go) begin
               r_state    <= ST_BURST;
               r_eng_busy <= 1'b1;
            end
         end else begin
            if (w_step) begin
               r_eng_data  <= read_data_Mat_i;
               r_eng_valid <= 1'b1;
               r_eng_last  <= w_last;
            end else if (r_eng_valid && eng_ready_i) begin
               r_eng_valid <= 1'b0;
               r_eng_last  <= 1'b0;
            end
            if (w_hs_last) begin
               r_state      <= ST_IDLE;
               r_eng_busy   <= 1'b0;
               r_last_owner <= OWN_ENG;
            end
         end
      end
   end

   assign host_gnt_o       = w_host_gnt;
   assign host_rvalid_o    = r_host_rvalid;
   assign host_rdata_o     = r_host_rdata;
   assign eng_busy_o       = r_eng_busy;
   assign eng_valid_o      = r_eng_valid;
   assign eng_data_o       = r_eng_data;
   assign eng_last_o       = r_eng_last;
   assign addr_Mat_o       = w_addr;
   assign write_data_Mat_o = w_wdata;
   assign write_en_Mat_o   = w_we;

endmodule

// File: tb/tb_operand_reg_arbiter.sv
// Randomised bench for operand_reg_arbiter: a behavioural register model plus
// expected-word queues derived from the arbitration and burst rules.
module tb_operand_reg_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned MS = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          host_req, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          eng_start, eng_busy, eng_valid, eng_ready, eng_last;
   logic [AW-1:0] eng_base;
   logic [AW:0]   eng_len;
   logic [DW-1:0] eng_data;
   logic [AW-1:0] addr_mat;
   logic [DW-1:0] wdata_mat, rdata_mat;
   logic          we_mat;

   logic [DW-1:0] mem     [MS];
   logic [DW-1:0] ref_mem [MS];
   logic [DW:0]   got_q [$];
   int            ready_mode = 0;
   int            errs = 0;
   int            checks = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_data = '0;

   always #5 clk = ~clk;

   operand_reg_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(MS)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
      .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
      .host_rdata_o(host_rdata),
      .eng_start_i(eng_start), .eng_base_i(eng_base), .eng_len_i(eng_len),
      .eng_busy_o(eng_busy), .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
      .eng_data_o(eng_data), .eng_last_o(eng_last),
      .addr_Mat_o(addr_mat), .write_data_Mat_o(wdata_mat), .write_en_Mat_o(we_mat),
      .read_data_Mat_i(rdata_mat)
   );

   // The operand register itself: combinational read, write at the edge.
   assign rdata_mat = mem[addr_mat];
   always @(posedge clk) if (we_mat) mem[addr_mat] <= wdata_mat;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Engine ready: 0 = always ready, 1 = random stalls, 2 = never ready.
   initial forever begin
      @(posedge clk);
      #1;
      eng_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
   end

   // Collect handshaken words and check that stalled words are held.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_hold_valid", 32'(eng_valid), 32'd1);
            chk("stall_hold_data", eng_data, stall_data);
         end
         if (eng_valid && eng_ready) got_q.push_back({eng_last, eng_data});
         stall_prev = eng_valid && !eng_ready;
         stall_data = eng_data;
      end
   end

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      chk("wr_gnt", 32'(host_gnt), 32'd1);
      chk("wr_we", 32'(we_mat), 32'd1);
      chk("wr_addr", 32'(addr_mat), 32'(a));
      cyc();
      host_req = 1'b0;
      ref_mem[a] = d;
      @(negedge clk);
      chk("wr_we_drop", 32'(we_mat), 32'd0);
      cyc();
   endtask

   task automatic host_read(input logic [AW-1:0] a);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      @(negedge clk);
      chk("rd_gnt", 32'(host_gnt), 32'd1);
      chk("rd_we", 32'(we_mat), 32'd0);
      cyc();
      host_req = 1'b0;
      chk("rd_rvalid", 32'(host_rvalid), 32'd1);
      chk("rd_data", host_rdata, ref_mem[a]);
      cyc();
      chk("rd_rvalid_drop", 32'(host_rvalid), 32'd0);
   endtask

   task automatic check_words(input int base, input int n);
      chk("burst_count", 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         chk("burst_word", got_q[i][DW-1:0], ref_mem[(base + i) % MS]);
         chk("burst_last", 32'(got_q[i][DW]), 32'(i == n - 1));
      end
   endtask

   task automatic run_burst(input int base, input int len, input int rmode, input bit lat);
      int n, budget;
      n = (len > MS) ? MS : len;
      ready_mode = rmode;
      got_q.delete();
      eng_start = 1'b1; eng_base = AW'(base); eng_len = (AW + 1)'(len);
      cyc();
      eng_start = 1'b0;
      if (lat) begin
         chk("lat_n1_valid", 32'(eng_valid), 32'd0);
         chk("lat_n1_busy", 32'(eng_busy), 32'd1);
         cyc();
         chk("lat_n2_valid", 32'(eng_valid), 32'd1);
      end
      budget = 0;
      while (eng_busy && budget < 300) begin
         cyc();
         budget++;
      end
      chk("burst_in_budget", 32'(budget < 300), 32'd1);
      chk("burst_valid_after", 32'(eng_valid), 32'd0);
      check_words(base, n);
      ready_mode = 0;
      cyc();
   endtask

   initial begin
      int budget;
      rst_n = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      eng_start = 1'b0; eng_base = '0; eng_len = '0; eng_ready = 1'b1;
      cyc(); cyc();
      chk("rst_gnt", 32'(host_gnt), 32'd0);
      chk("rst_rvalid", 32'(host_rvalid), 32'd0);
      chk("rst_busy", 32'(eng_busy), 32'd0);
      chk("rst_valid", 32'(eng_valid), 32'd0);
      chk("rst_we", 32'(we_mat), 32'd0);
      chk("rst_addr", 32'(addr_mat), 32'd0);
      rst_n = 1'b1;
      cyc();

      host_write(4'd2, 32'd88);
      host_read(4'd2);

      for (int a = 0; a < MS; a++) host_write(AW'(a), DW'(8 * a));
      run_burst(0, 16, 0, 1'b1);
      run_burst(14, 4, 1, 1'b0);

      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 1) == 1) host_write(AW'($urandom_range(0, 15)), $urandom);
         else host_read(AW'($urandom_range(0, 15)));
      end
      for (int k = 0; k < 6; k++)
         run_burst(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)), 1, 1'b0);

      // Conflict sequence starting from a fresh round-robin state.
      rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
      got_q.delete();
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
      eng_start = 1'b1; eng_base = 4'd4; eng_len = 5'd2;
      @(negedge clk);
      chk("c1_host_wins", 32'(host_gnt), 32'd1);
      cyc();
      chk("c1_start_dropped", 32'(eng_busy), 32'd0);
      chk("c1_rvalid", 32'(host_rvalid), 32'd1);
      chk("c1_rdata", host_rdata, ref_mem[3]);
      host_addr = 4'd5;
      @(negedge clk);
      chk("c2_host_loses", 32'(host_gnt), 32'd0);
      cyc();
      eng_start = 1'b0;
      chk("c2_eng_busy", 32'(eng_busy), 32'd1);
      budget = 0;
      while (eng_busy && budget < 50) begin
         @(negedge clk);
         chk("c2_gnt_withheld", 32'(host_gnt), 32'd0);
         cyc();
         budget++;
      end
      @(negedge clk);
      chk("c2_gnt_after_burst", 32'(host_gnt), 32'd1);
      chk("c2_gnt_addr", 32'(addr_mat), 32'd5);
      cyc();
      host_req = 1'b0;
      chk("c2_rdata", host_rdata, ref_mem[5]);
      check_words(4, 2);
      host_req = 1'b1; host_addr = 4'd7;
      eng_start = 1'b1; eng_base = 4'd0; eng_len = 5'd3;
      @(negedge clk);
      chk("c3_host_wins_after_burst", 32'(host_gnt), 32'd1);
      cyc();
      host_req = 1'b0; eng_start = 1'b0;
      chk("c3_start_dropped", 32'(eng_busy), 32'd0);
      chk("c3_rdata", host_rdata, ref_mem[7]);
      cyc();

      // Zero-length start is ignored; oversize length clamps.
      eng_start = 1'b1; eng_base = 4'd3; eng_len = 5'd0;
      cyc();
      eng_start = 1'b0;
      chk("len0_busy", 32'(eng_busy), 32'd0);
      cyc();
      chk("len0_valid", 32'(eng_valid), 32'd0);
      run_burst(5, 20, 0, 1'b0);

      // Asynchronous reset in the middle of a burst.
      eng_start = 1'b1; eng_base = 4'd0; eng_len = 5'd16;
      cyc();
      eng_start = 1'b0;
      cyc(); cyc(); cyc();
      chk("mid_busy_before", 32'(eng_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(eng_busy), 32'd0);
      chk("mid_rst_valid", 32'(eng_valid), 32'd0);
      chk("mid_rst_last", 32'(eng_last), 32'd0);
      chk("mid_rst_data", eng_data, 32'd0);
      chk("mid_rst_addr", 32'(addr_mat), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      chk("post_rst_busy", 32'(eng_busy), 32'd0);
      chk("post_rst_valid", 32'(eng_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
